// File: rtl/bnn_array_sequencer_pkg.sv
// Shared sizing, FSM encoding and result-beat payload for the BNN array sequencer.
package bnn_array_sequencer_pkg;

  localparam int unsigned O_CH           = 64;
  localparam int unsigned OUT_ROW_LENGTH = 4;
  localparam int unsigned DATA_W         = 9;
  localparam int unsigned DRAIN_CYCLES   = 66;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned CH_W           = 6;
  localparam int unsigned AW             = (O_CH > 1) ? $clog2(O_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_ACT    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_POP    = 3'd5,
    ST_EMIT   = 3'd6
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0]           ch;
    logic [OUT_ROW_LENGTH-1:0] data;
  } res_beat_t;

endpackage

// File: rtl/bnn_array_sequencer_if.sv
// Host command, weight/activation stream, array pins and result stream of the sequencer.
interface bnn_array_sequencer_if;
  import bnn_array_sequencer_pkg::*;

  logic                      cmd_valid_in;
  logic                      cmd_ready_out;
  logic                      cmd_load_w_in;
  logic [CNT_W-1:0]          cmd_num_act_in;
  logic [DATA_W-1:0]         s_data_in;
  logic                      s_valid_in;
  logic                      s_ready_out;
  logic [DATA_W-1:0]         chip_data_out;
  logic                      chip_load_w_out;
  logic                      chip_valid_out;
  logic                      chip_pop_out;
  logic                      chip_clr_n_out;
  logic [OUT_ROW_LENGTH-1:0] chip_sum_in;
  logic                      res_valid_out;
  logic                      res_ready_in;
  logic [CH_W-1:0]           res_ch_out;
  logic [OUT_ROW_LENGTH-1:0] res_data_out;

  modport slave (
    input  cmd_valid_in, cmd_load_w_in, cmd_num_act_in, s_data_in, s_valid_in,
           chip_sum_in, res_ready_in,
    output cmd_ready_out, s_ready_out, chip_data_out, chip_load_w_out, chip_valid_out,
           chip_pop_out, chip_clr_n_out, res_valid_out, res_ch_out, res_data_out
  );

  modport master (
    output cmd_valid_in, cmd_load_w_in, cmd_num_act_in, s_data_in, s_valid_in,
           chip_sum_in, res_ready_in,
    input  cmd_ready_out, s_ready_out, chip_data_out, chip_load_w_out, chip_valid_out,
           chip_pop_out, chip_clr_n_out, res_valid_out, res_ch_out, res_data_out
  );

endinterface

// File: rtl/bnn_array_sequencer_result_buffer.sv
// Per-channel sign-bit store: written once per pop cycle, read back as valid/ready beats.
module bnn_array_sequencer_result_buffer
  import bnn_array_sequencer_pkg::*;
(
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             wr_addr_i,
  input  logic [OUT_ROW_LENGTH-1:0] wr_data_i,
  input  logic                      rd_start_i,
  input  logic                      res_ready_i,
  output logic                      res_valid_o,
  output logic [CH_W-1:0]           res_ch_o,
  output logic [OUT_ROW_LENGTH-1:0] res_data_o
);

  logic [OUT_ROW_LENGTH-1:0] mem_q [O_CH];
  res_beat_t                 beat_q, beat_d;
  logic                      valid_q, valid_d;
  logic                      last_c;
  logic [AW-1:0]             next_idx_c;

  always_ff @(posedge clk_in) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign last_c     = (beat_q.ch == CH_W'(O_CH - 1));
  assign next_idx_c = AW'(beat_q.ch) + AW'(1);

  // Beat registers only advance on a handshake, so a stalled beat holds steady.
  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    if (rd_start_i) begin
      valid_d     = 1'b1;
      beat_d.ch   = '0;
      beat_d.data = mem_q[0];
    end else if (valid_q && res_ready_i) begin
      if (last_c) begin
        valid_d = 1'b0;
      end else begin
        beat_d.ch   = beat_q.ch + CH_W'(1);
        beat_d.data = mem_q[next_idx_c];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign res_valid_o = valid_q;
  assign res_ch_o    = beat_q.ch;
  assign res_data_o  = beat_q.data;

endmodule

// File: rtl/bnn_array_sequencer.sv
// Job sequencer for the BNN PE array: weight reload, activation feed, drain, pop capture, result emit.
module bnn_array_sequencer
  import bnn_array_sequencer_pkg::*;
(
  input logic                  clk_in,
  input logic                  rst_in,
  bnn_array_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [DATA_W-1:0]  chip_data_q, chip_data_d;
  logic               chip_load_w_q, chip_load_w_d;
  logic               chip_valid_q, chip_valid_d;
  logic               chip_pop_q, chip_pop_d;
  logic               chip_clr_n_q, chip_clr_n_d;
  logic               s_ready_c, s_hs_c, rd_start_c, emit_done_c;

  assign s_ready_c   = (state_q == ST_LOAD_W) || (state_q == ST_ACT);
  assign s_hs_c      = bus.s_valid_in && s_ready_c;
  assign emit_done_c = bus.res_valid_out && bus.res_ready_in &&
                       (bus.res_ch_out == CH_W'(O_CH - 1));

  // Next-state and registered chip pin values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    rd_start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_in) begin
          num_d   = bus.cmd_num_act_in;
          cnt_d   = '0;
          state_d = bus.cmd_load_w_in ? ST_LOAD_W : ST_CLEAR;
        end
      end
      ST_LOAD_W: begin
        if (s_hs_c) begin
          if (cnt_q == CNT_W'(O_CH - 1)) begin
            cnt_d   = '0;
            state_d = ST_CLEAR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = (num_q == '0) ? ST_DRAIN : ST_ACT;
      end
      ST_ACT: begin
        if (s_hs_c) begin
          if (cnt_q == num_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // One extra cycle absorbs the strobe of the last accepted word.
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
          cnt_d   = '0;
          state_d = ST_POP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_POP: begin
        if (cnt_q == CNT_W'(O_CH - 1)) begin
          cnt_d      = '0;
          rd_start_c = 1'b1;
          state_d    = ST_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        if (emit_done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    chip_data_d   = s_hs_c ? bus.s_data_in : '0;
    chip_load_w_d = s_hs_c && (state_q == ST_LOAD_W);
    chip_valid_d  = s_hs_c && (state_q == ST_ACT);
    chip_pop_d    = (state_d == ST_POP);
    chip_clr_n_d  = (state_q != ST_CLEAR);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      num_q         <= '0;
      chip_data_q   <= '0;
      chip_load_w_q <= 1'b0;
      chip_valid_q  <= 1'b0;
      chip_pop_q    <= 1'b0;
      chip_clr_n_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      num_q         <= num_d;
      chip_data_q   <= chip_data_d;
      chip_load_w_q <= chip_load_w_d;
      chip_valid_q  <= chip_valid_d;
      chip_pop_q    <= chip_pop_d;
      chip_clr_n_q  <= chip_clr_n_d;
    end
  end

  assign bus.cmd_ready_out   = (state_q == ST_IDLE);
  assign bus.s_ready_out     = s_ready_c;
  assign bus.chip_data_out   = chip_data_q;
  assign bus.chip_load_w_out = chip_load_w_q;
  assign bus.chip_valid_out  = chip_valid_q;
  assign bus.chip_pop_out    = chip_pop_q;
  assign bus.chip_clr_n_out  = chip_clr_n_q;

  bnn_array_sequencer_result_buffer u_buf (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_en_i     (state_q == ST_POP),
    .wr_addr_i   (cnt_q[AW-1:0]),
    .wr_data_i   (bus.chip_sum_in),
    .rd_start_i  (rd_start_c),
    .res_ready_i (bus.res_ready_in),
    .res_valid_o (bus.res_valid_out),
    .res_ch_o    (bus.res_ch_out),
    .res_data_o  (bus.res_data_out)
  );

endmodule

// File: tb/tb_bnn_array_sequencer.sv
// Bench for bnn_array_sequencer with a behavioural PE-array load and a golden popcount scoreboard.
module tb_bnn_array_sequencer;
  import bnn_array_sequencer_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  bnn_array_sequencer_if bus ();
  bnn_array_sequencer dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit load_w;
    int num_act;
    int act_kind;   // 0: all 9'h1FF, 1: random
    int w_kind;     // 0: weight of ch k = k, 1: random
    int gap;        // percent of idle stream cycles
    int exp_lw;
    int exp_val;
  } job_t;

  logic [DATA_W-1:0] gw [O_CH];
  logic [DATA_W-1:0] aq [$];
  logic [DATA_W-1:0] sq [$];
  res_beat_t         exp_q [$];

  function automatic int xnor_score(logic [DATA_W-1:0] w, logic [DATA_W-1:0] a);
    return 2 * $countones(~(w ^ a)) - int'(DATA_W);
  endfunction

  // Behavioural array: shift-in weights, per-position XNOR accumulation, pop counter.
  logic [DATA_W-1:0] arr_w [O_CH];
  int                arr_acc [O_CH][OUT_ROW_LENGTH];
  int                arr_n  = 0;
  int                arr_pc = 0;

  always @(posedge clk_in) begin
    if (!bus.chip_clr_n_out) begin
      for (int c = 0; c < O_CH; c++)
        for (int p = 0; p < OUT_ROW_LENGTH; p++) arr_acc[c][p] <= 0;
      arr_n <= 0;
    end else if (bus.chip_valid_out) begin
      for (int c = 0; c < O_CH; c++)
        arr_acc[c][arr_n % OUT_ROW_LENGTH] <= arr_acc[c][arr_n % OUT_ROW_LENGTH]
                                              + xnor_score(arr_w[c], bus.chip_data_out);
      arr_n <= arr_n + 1;
    end
    if (bus.chip_load_w_out) begin
      arr_w[0] <= bus.chip_data_out;
      for (int c = 1; c < O_CH; c++) arr_w[c] <= arr_w[c-1];
    end
    arr_pc <= bus.chip_pop_out ? (arr_pc + 1) % O_CH : 0;
  end

  always_comb begin
    for (int p = 0; p < OUT_ROW_LENGTH; p++) bus.chip_sum_in[p] = (arr_acc[arr_pc][p] > 0);
  end

  // Pin activity monitor.
  int cyc = 0, clr_cnt, clr_cyc, val_cnt, first_val, last_val, lw_cnt;
  int pop_cnt, pop_runs, first_pop, data_nz, coinc = 0;
  bit pop_prev = 1'b0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      cyc++;
      if (!bus.chip_clr_n_out) begin
        clr_cnt++;
        clr_cyc = cyc;
        if (bus.chip_valid_out || bus.chip_load_w_out) coinc++;
      end
      if (bus.chip_valid_out) begin
        val_cnt++;
        last_val = cyc;
        if (first_val < 0) first_val = cyc;
      end
      if (bus.chip_load_w_out) lw_cnt++;
      if (!bus.chip_valid_out && !bus.chip_load_w_out && bus.chip_data_out != '0) data_nz++;
      if (bus.chip_pop_out) begin
        pop_cnt++;
        if (!pop_prev) begin
          pop_runs++;
          first_pop = cyc;
        end
      end
      pop_prev = bus.chip_pop_out;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic clear_monitor();
    clr_cnt = 0; clr_cyc = -1; val_cnt = 0; first_val = -1; last_val = -1;
    lw_cnt = 0; pop_cnt = 0; pop_runs = 0; first_pop = -1; data_nz = 0;
  endtask

  task automatic push_expected();
    for (int c = 0; c < O_CH; c++) begin
      int        acc [OUT_ROW_LENGTH];
      res_beat_t b;
      for (int p = 0; p < OUT_ROW_LENGTH; p++) acc[p] = 0;
      for (int j = 0; j < aq.size(); j++)
        acc[j % OUT_ROW_LENGTH] += xnor_score(gw[c], aq[j]);
      b.ch = CH_W'(c);
      for (int p = 0; p < OUT_ROW_LENGTH; p++) b.data[p] = (acc[p] > 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_cmd(input bit load_w, input int num);
    int budget = 200;
    @(negedge clk_in);
    bus.cmd_valid_in   = 1'b1;
    bus.cmd_load_w_in  = load_w;
    bus.cmd_num_act_in = CNT_W'(num);
    while (!bus.cmd_ready_out && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    if (budget == 0) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(negedge clk_in);
    bus.cmd_valid_in = 1'b0;
  endtask

  task automatic drive_stream(input int gap, input int max_words);
    int sent   = 0;
    int budget = 5000;
    while (sent < max_words && sent < sq.size() && budget > 0) begin
      @(negedge clk_in);
      budget--;
      bus.s_valid_in = ($urandom_range(99) >= gap);
      bus.s_data_in  = bus.s_valid_in ? sq[sent] : '0;
      if (bus.s_valid_in && bus.s_ready_out) sent++;
    end
    if (budget == 0) check("stream_timeout", 32'(sent), 32'(max_words));
    @(negedge clk_in);
    bus.s_valid_in = 1'b0;
    bus.s_data_in  = '0;
  endtask

  task automatic run_job(input job_t j, input bit stall);
    int        budget     = 3000;
    int        stall_left = stall ? 10 : 0;
    int        nbeat      = 0;
    bit        holding    = 1'b0;
    logic [OUT_ROW_LENGTH-1:0] held = '0;
    res_beat_t e;

    aq.delete();
    sq.delete();
    for (int i = 0; i < j.num_act; i++)
      aq.push_back(j.act_kind == 0 ? DATA_W'(9'h1FF) : DATA_W'($urandom));
    if (j.load_w) begin
      for (int c = 0; c < O_CH; c++) gw[c] = (j.w_kind == 0) ? DATA_W'(c) : DATA_W'($urandom);
      for (int c = O_CH - 1; c >= 0; c--) sq.push_back(gw[c]);
    end
    foreach (aq[i]) sq.push_back(aq[i]);
    push_expected();
    clear_monitor();

    issue_cmd(j.load_w, j.num_act);
    drive_stream(j.gap, sq.size());

    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk_in);
      budget--;
      if (stall_left > 0 && nbeat == 5 && bus.res_valid_out) begin
        if (holding) check("stall_data", 32'(bus.res_data_out), 32'(held));
        else begin
          holding = 1'b1;
          held    = bus.res_data_out;
        end
        check("stall_ch", 32'(bus.res_ch_out), 32'd5);
        check("stall_cmd_ready", 32'(bus.cmd_ready_out), 32'd0);
        bus.res_ready_in = 1'b0;
        stall_left--;
      end else begin
        bus.res_ready_in = 1'b1;
      end
      if (bus.res_valid_out && bus.res_ready_in) begin
        e = exp_q.pop_front();
        check("beat_ch", 32'(bus.res_ch_out), 32'(e.ch));
        check("beat_data", 32'(bus.res_data_out), 32'(e.data));
        check("emit_cmd_ready", 32'(bus.cmd_ready_out), 32'd0);
        nbeat++;
      end
    end
    if (budget == 0) check("emit_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk_in);
    check("idle_after_emit", 32'(bus.cmd_ready_out), 32'd1);

    check("load_strobes", 32'(lw_cnt), 32'(j.exp_lw));
    check("valid_strobes", 32'(val_cnt), 32'(j.exp_val));
    check("clr_len", 32'(clr_cnt), 32'd1);
    check("pop_len", 32'(pop_cnt), 32'(O_CH));
    check("pop_runs", 32'(pop_runs), 32'd1);
    check("data_idle_zero", 32'(data_nz), 32'd0);
    check("clr_overlap", 32'(coinc), 32'd0);
    if (j.num_act > 0) check("drain_gap", 32'(first_pop - last_val), 32'(DRAIN_CYCLES + 1));
    if (j.num_act > 0 && j.gap == 0) check("clr_to_valid", 32'(first_val - clr_cyc), 32'd1);
  endtask

  job_t jobs [4];
  job_t hj;

  initial begin
    jobs[0] = '{1'b1, 4,  0, 0, 0,  64, 4};
    jobs[1] = '{1'b0, 8,  1, 0, 0,  0,  8};
    jobs[2] = '{1'b1, 12, 1, 1, 50, 64, 12};
    jobs[3] = '{1'b0, 0,  0, 0, 0,  0,  0};

    bus.cmd_valid_in   = 1'b0;
    bus.cmd_load_w_in  = 1'b0;
    bus.cmd_num_act_in = '0;
    bus.s_data_in      = '0;
    bus.s_valid_in     = 1'b0;
    bus.res_ready_in   = 1'b1;
    rst_in             = 1'b0;
    clear_monitor();

    repeat (3) @(negedge clk_in);
    check("rst_chip_data", 32'(bus.chip_data_out), 32'd0);
    check("rst_chip_load", 32'(bus.chip_load_w_out), 32'd0);
    check("rst_chip_valid", 32'(bus.chip_valid_out), 32'd0);
    check("rst_chip_pop", 32'(bus.chip_pop_out), 32'd0);
    check("rst_chip_clr_n", 32'(bus.chip_clr_n_out), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid_out), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready_out), 32'd1);
    check("rst_s_ready", 32'(bus.s_ready_out), 32'd0);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("idle_clr_n", 32'(bus.chip_clr_n_out), 32'd1);

    for (int i = 0; i < 4; i++) run_job(jobs[i], 1'b0);

    hj = '{1'b0, 4, 1, 0, 0, 0, 4};
    run_job(hj, 1'b1);

    // Reset in the middle of an activation stream.
    aq.delete();
    sq.delete();
    for (int i = 0; i < 8; i++) sq.push_back(DATA_W'($urandom));
    clear_monitor();
    issue_cmd(1'b0, 8);
    drive_stream(0, 3);
    check("pre_rst_valid", 32'(bus.chip_valid_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check("midrst_chip_data", 32'(bus.chip_data_out), 32'd0);
    check("midrst_chip_load", 32'(bus.chip_load_w_out), 32'd0);
    check("midrst_chip_valid", 32'(bus.chip_valid_out), 32'd0);
    check("midrst_chip_pop", 32'(bus.chip_pop_out), 32'd0);
    check("midrst_chip_clr_n", 32'(bus.chip_clr_n_out), 32'd0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready_out), 32'd1);
    check("midrst_s_ready", 32'(bus.s_ready_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);

    hj = '{1'b1, 8, 1, 1, 25, 64, 8};
    run_job(hj, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
